// File: rtl/reg_file_pkg.sv
// Shared widths and types for the architectural register file.
// Every rtl/ file imports this package.
package reg_file_pkg;

    localparam int DATA_WID    = 32;
    localparam int REG_POS_WID = 5;
    localparam int ROB_POS_WID = 4;
    localparam int REG_NUM     = 32;

    typedef logic [REG_POS_WID-1:0] reg_idx_t;

    function automatic logic is_x0(input reg_idx_t idx);
        return idx == '0;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Commit, issue, rollback and operand-query signals between core and register file.
// The core drives through the master modport; the register file uses the slave modport.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W    = DATA_WID,
    parameter int ROB_POS_W = ROB_POS_WID
);

    logic                 rollback;

    logic                 issue;
    reg_idx_t             issue_rd;
    logic [ROB_POS_W-1:0] issue_rob_pos;

    logic                 reg_write;
    reg_idx_t             reg_rd;
    logic [DATA_W-1:0]    reg_val;
    logic [ROB_POS_W-1:0] commit_rob_pos;

    reg_idx_t             rs1;
    logic [DATA_W-1:0]    rs1_val;
    logic                 rs1_busy;
    logic [ROB_POS_W-1:0] rs1_rob_pos;

    reg_idx_t             rs2;
    logic [DATA_W-1:0]    rs2_val;
    logic                 rs2_busy;
    logic [ROB_POS_W-1:0] rs2_rob_pos;

    modport master (
        output rollback,
        output issue, issue_rd, issue_rob_pos,
        output reg_write, reg_rd, reg_val, commit_rob_pos,
        output rs1, rs2,
        input  rs1_val, rs1_busy, rs1_rob_pos,
        input  rs2_val, rs2_busy, rs2_rob_pos
    );

    modport slave (
        input  rollback,
        input  issue, issue_rd, issue_rob_pos,
        input  reg_write, reg_rd, reg_val, commit_rob_pos,
        input  rs1, rs2,
        output rs1_val, rs1_busy, rs1_rob_pos,
        output rs2_val, rs2_busy, rs2_rob_pos
    );

endinterface

// File: rtl/reg_file_rd_port.sv
// One combinational operand-query port of the register file.
// A matching commit in the same cycle bypasses its value and clears busy.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int REG_NUM_P = REG_NUM,
    parameter int DATA_W    = DATA_WID,
    parameter int ROB_POS_W = ROB_POS_WID
) (
    input  logic [REG_NUM_P-1:0][DATA_W-1:0]    val_i,
    input  logic [REG_NUM_P-1:0]                busy_i,
    input  logic [REG_NUM_P-1:0][ROB_POS_W-1:0] tag_i,
    input  logic                                reg_write_i,
    input  reg_idx_t                            reg_rd_i,
    input  logic [DATA_W-1:0]                   reg_val_i,
    input  logic [ROB_POS_W-1:0]                commit_rob_pos_i,
    input  reg_idx_t                            rs_i,
    output logic [DATA_W-1:0]                   rs_val_o,
    output logic                                rs_busy_o,
    output logic [ROB_POS_W-1:0]                rs_rob_pos_o
);

    logic [DATA_W-1:0]    val_sel;
    logic                 busy_sel;
    logic [ROB_POS_W-1:0] tag_sel;
    logic                 hit;

    assign val_sel  = val_i[rs_i];
    assign busy_sel = busy_i[rs_i];
    assign tag_sel  = tag_i[rs_i];

    assign hit = reg_write_i
              && (reg_rd_i == rs_i)
              && !is_x0(rs_i)
              && busy_sel
              && (tag_sel == commit_rob_pos_i);

    always_comb begin
        rs_val_o     = val_sel;
        rs_busy_o    = busy_sel;
        rs_rob_pos_o = tag_sel;
        if (is_x0(rs_i)) begin
            rs_val_o  = '0;
            rs_busy_o = 1'b0;
        end else if (hit) begin
            rs_val_o  = reg_val_i;
            rs_busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register busy bit and producer ROB tag.
// Writes come from ROB commit, renames from issue; rollback clears all busy bits.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int REG_NUM_P = REG_NUM,
    parameter int DATA_W    = DATA_WID,
    parameter int ROB_POS_W = ROB_POS_WID
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    reg_file_if.slave  bus
);

    logic [REG_NUM_P-1:0][DATA_W-1:0]    val_q, val_d;
    logic [REG_NUM_P-1:0]                busy_q, busy_d;
    logic [REG_NUM_P-1:0][ROB_POS_W-1:0] tag_q, tag_d;

    logic do_write;
    logic do_issue;
    logic commit_clears;

    assign do_write = bus.reg_write && !is_x0(bus.reg_rd);
    assign do_issue = bus.issue && !is_x0(bus.issue_rd) && !bus.rollback;

    // A stale commit (older tag) must not clear a newer rename.
    assign commit_clears = busy_q[bus.reg_rd]
                        && (tag_q[bus.reg_rd] == bus.commit_rob_pos);

    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rdy) begin
            if (bus.rollback) begin
                busy_d = '0;
            end
            if (do_write) begin
                val_d[bus.reg_rd] = bus.reg_val;
                if (commit_clears) begin
                    busy_d[bus.reg_rd] = 1'b0;
                end
            end
            // Issue is applied last so a same-cycle rename wins over the clear.
            if (do_issue) begin
                busy_d[bus.issue_rd] = 1'b1;
                tag_d[bus.issue_rd]  = bus.issue_rob_pos;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q  <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    reg_file_rd_port #(
        .REG_NUM_P (REG_NUM_P),
        .DATA_W    (DATA_W),
        .ROB_POS_W (ROB_POS_W)
    ) u_rd_port1 (
        .val_i            (val_q),
        .busy_i           (busy_q),
        .tag_i            (tag_q),
        .reg_write_i      (bus.reg_write),
        .reg_rd_i         (bus.reg_rd),
        .reg_val_i        (bus.reg_val),
        .commit_rob_pos_i (bus.commit_rob_pos),
        .rs_i             (bus.rs1),
        .rs_val_o         (bus.rs1_val),
        .rs_busy_o        (bus.rs1_busy),
        .rs_rob_pos_o     (bus.rs1_rob_pos)
    );

    reg_file_rd_port #(
        .REG_NUM_P (REG_NUM_P),
        .DATA_W    (DATA_W),
        .ROB_POS_W (ROB_POS_W)
    ) u_rd_port2 (
        .val_i            (val_q),
        .busy_i           (busy_q),
        .tag_i            (tag_q),
        .reg_write_i      (bus.reg_write),
        .reg_rd_i         (bus.reg_rd),
        .reg_val_i        (bus.reg_val),
        .commit_rob_pos_i (bus.commit_rob_pos),
        .rs_i             (bus.rs2),
        .rs_val_o         (bus.rs2_val),
        .rs_busy_o        (bus.rs2_busy),
        .rs_rob_pos_o     (bus.rs2_rob_pos)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: stimulus pushes expected query results,
// a monitor pops and compares them against the live query outputs.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk;
    logic rst;
    logic rdy;

    reg_file_if #(.DATA_W(32), .ROB_POS_W(4)) bus ();

    reg_file dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          port2;
        logic [31:0] val;
        logic        busy;
        logic [3:0]  pos;
        bit          chk_pos;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    event chk_now;

    task automatic push_exp(input string n, input bit p2, input logic [31:0] v,
                            input logic b, input logic [3:0] p, input bit cp);
        exp_t e;
        e.name = n;
        e.port2 = p2;
        e.val = v;
        e.busy = b;
        e.pos = p;
        e.chk_pos = cp;
        exp_q.push_back(e);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clk or chk_now);
            while (exp_q.size() > 0) begin
                exp_t        e;
                logic [31:0] av;
                logic        ab;
                logic [3:0]  ap;
                e  = exp_q.pop_front();
                av = e.port2 ? bus.rs2_val     : bus.rs1_val;
                ab = e.port2 ? bus.rs2_busy    : bus.rs1_busy;
                ap = e.port2 ? bus.rs2_rob_pos : bus.rs1_rob_pos;
                checks++;
                if (av !== e.val || ab !== e.busy || (e.chk_pos && ap !== e.pos)) begin
                    errors++;
                    $display("FAIL %s: got val=%h busy=%b pos=%h, want val=%h busy=%b pos=%h",
                             e.name, av, ab, ap, e.val, e.busy, e.pos);
                end
            end
        end
    end

    task automatic idle();
        bus.rollback       = 1'b0;
        bus.issue          = 1'b0;
        bus.issue_rd       = '0;
        bus.issue_rob_pos  = '0;
        bus.reg_write      = 1'b0;
        bus.reg_rd         = '0;
        bus.reg_val        = '0;
        bus.commit_rob_pos = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [3:0] pos);
        bus.issue         = 1'b1;
        bus.issue_rd      = rd;
        bus.issue_rob_pos = pos;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [3:0] pos,
                             input logic [31:0] v);
        bus.reg_write      = 1'b1;
        bus.reg_rd         = rd;
        bus.commit_rob_pos = pos;
        bus.reg_val        = v;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        rdy = 1'b1;
        bus.rs1 = 5'd5;
        bus.rs2 = 5'd0;
        #1;
        push_exp("reset_rs1", 0, 32'h0, 1'b0, 4'h0, 1);
        push_exp("reset_rs2", 1, 32'h0, 1'b0, 4'h0, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // rename x5 -> pos 3, then commit it
        step();
        do_issue(5'd5, 4'd3);
        bus.rs1 = 5'd5;
        push_exp("issue_same_cycle", 0, 32'h0, 1'b0, 4'h0, 0);
        step();
        push_exp("rename_visible", 0, 32'h0, 1'b1, 4'd3, 1);
        step();
        do_commit(5'd5, 4'd3, 32'hDEADBEEF);
        push_exp("commit_bypass", 0, 32'hDEADBEEF, 1'b0, 4'd3, 1);
        step();
        push_exp("commit_state", 0, 32'hDEADBEEF, 1'b0, 4'd0, 0);

        // stale commit on x7
        step();
        do_issue(5'd7, 4'd2);
        step();
        do_issue(5'd7, 4'd6);
        step();
        do_commit(5'd7, 4'd2, 32'h11);
        bus.rs2 = 5'd7;
        push_exp("stale_no_bypass", 1, 32'h0, 1'b1, 4'd6, 1);
        step();
        push_exp("stale_state", 1, 32'h11, 1'b1, 4'd6, 1);

        // simultaneous issue and commit on x9
        step();
        do_issue(5'd9, 4'd1);
        step();
        do_issue(5'd9, 4'd4);
        do_commit(5'd9, 4'd1, 32'h22);
        bus.rs1 = 5'd9;
        push_exp("iss_com_bypass", 0, 32'h22, 1'b0, 4'd1, 1);
        step();
        push_exp("iss_com_state", 0, 32'h22, 1'b1, 4'd4, 1);

        // rollback with JALR link commit
        step();
        do_issue(5'd1, 4'd5);
        step();
        bus.rollback = 1'b1;
        do_commit(5'd1, 4'd5, 32'h1000);
        do_issue(5'd2, 4'd7);
        bus.rs1 = 5'd1;
        bus.rs2 = 5'd2;
        push_exp("rb_jalr_bypass", 0, 32'h1000, 1'b0, 4'd5, 1);
        step();
        push_exp("rb_x1_state", 0, 32'h1000, 1'b0, 4'd5, 1);
        push_exp("rb_x2_not_renamed", 1, 32'h0, 1'b0, 4'd0, 1);
        step();
        bus.rs1 = 5'd7;
        bus.rs2 = 5'd9;
        push_exp("rb_x7_clear", 0, 32'h11, 1'b0, 4'd6, 1);
        push_exp("rb_x9_clear", 1, 32'h22, 1'b0, 4'd4, 1);

        // x0 writes and renames are dropped
        step();
        do_issue(5'd0, 4'd3);
        do_commit(5'd0, 4'd0, 32'h99);
        bus.rs1 = 5'd0;
        bus.rs2 = 5'd0;
        push_exp("x0_same_cycle", 0, 32'h0, 1'b0, 4'd0, 0);
        step();
        push_exp("x0_rs1", 0, 32'h0, 1'b0, 4'd0, 1);
        push_exp("x0_rs2", 1, 32'h0, 1'b0, 4'd0, 1);

        // rdy low holds all state
        step();
        rdy = 1'b0;
        do_commit(5'd3, 4'd0, 32'h55);
        do_issue(5'd4, 4'd2);
        bus.rs1 = 5'd3;
        bus.rs2 = 5'd5;
        push_exp("rdy0_live_query", 1, 32'hDEADBEEF, 1'b0, 4'd0, 0);
        step();
        rdy = 1'b1;
        bus.rs2 = 5'd4;
        push_exp("rdy0_x3_held", 0, 32'h0, 1'b0, 4'd0, 1);
        push_exp("rdy0_x4_held", 1, 32'h0, 1'b0, 4'd0, 1);

        // asynchronous reset with busy registers
        step();
        do_issue(5'd6, 4'd9);
        step();
        bus.rs1 = 5'd6;
        bus.rs2 = 5'd5;
        push_exp("pre_rst_busy", 0, 32'h0, 1'b1, 4'd9, 1);
        push_exp("pre_rst_val", 1, 32'hDEADBEEF, 1'b0, 4'd0, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        push_exp("async_rst_rs1", 0, 32'h0, 1'b0, 4'd0, 1);
        push_exp("async_rst_rs2", 1, 32'h0, 1'b0, 4'd0, 1);
        -> chk_now;
        #1;
        step();
        rst = 1'b1;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with rename table for the out-of-order RV32I core. It sits at the commit end of the reorder buffer and holds 32 architectural values plus a per-register busy bit and producing-ROB tag. It accepts register writes from ROB commit and renames from the decoder's issue stage. It answers two combinational operand queries for the decoder and drops all rename state on rollback.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hardwired zero.
- DATA_W, 32, register value width (matches `DATA_WID`).
- ROB_POS_W, 4, ROB tag width (matches `ROB_POS_WID`).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; when low, all state holds.
- rollback  in  1  misprediction flush from the ROB.
- issue  in  1  decoder issues an instruction this cycle.
- issue_rd  in  5  destination register of the issued instruction.
- issue_rob_pos  in  ROB_POS_W  ROB slot allocated to the issued instruction.
- reg_write  in  1  ROB commits a register write.
- reg_rd  in  5  committed destination register.
- reg_val  in  DATA_W  committed value.
- commit_rob_pos  in  ROB_POS_W  ROB slot being committed.
- rs1  in  5  decoder query, source 1.
- rs1_val  out  DATA_W  architectural or bypassed value of rs1.
- rs1_busy  out  1  rs1 awaits an in-flight producer.
- rs1_rob_pos  out  ROB_POS_W  producer tag of rs1; valid only when rs1_busy is high.
- rs2, rs2_val, rs2_busy, rs2_rob_pos: same as the rs1 group, for source 2.

## Operation
- State per register i: val[i] (DATA_W), busy[i] (1), tag[i] (ROB_POS_W).
- Reset, asynchronous on rst low: all val, busy and tag cleared to 0. Query outputs are combinational from state, so they read 0, 0, 0 for any query.
- Commit write, on reg_write && reg_rd != 0:
  - val[reg_rd] <= reg_val.
  - busy[reg_rd] is cleared only if busy[reg_rd] && tag[reg_rd] == commit_rob_pos. A newer rename keeps the register busy.
- Issue rename, on issue && issue_rd != 0 && !rollback: busy[issue_rd] <= 1 and tag[issue_rd] <= issue_rob_pos.
- Issue and commit to the same rd in the same cycle: the value is written, and the issue rename wins, so the register stays busy with the new tag.
- Rollback:
  - All busy bits clear and tags are untouched.
  - A reg_write in the same cycle still updates val. JALR commits its link value in the rollback cycle.
  - Issue in that cycle is ignored.
- x0 writes and renames are dropped, and queries of x0 return val 0 and busy 0.
- Query bypass: if reg_write && reg_rd == rsN && rsN != 0 && busy[rsN] && tag[rsN] == commit_rob_pos, then rsN_busy = 0 and rsN_val = reg_val. Otherwise rsN_val = val[rsN] and rsN_busy = busy[rsN].
- rdy low: no write, rename or clear takes effect. Queries remain live.

## Timing
- Commit write: visible on query outputs in the same cycle via the bypass, and in state from the next edge.
- Rename: visible to queries the cycle after issue. An instruction issued in cycle t+1 sees busy set by the issue in cycle t.
- Rollback: busy is clear from the edge that samples rollback. The first post-flush query, one cycle later, sees all registers ready.
- Query path: purely combinational. It is one 32:1 mux plus a compare chain, with no registered outputs.
- No handshake backpressure: the block accepts one commit and one issue every cycle.

## Structure
- Widths come from the shared macros header: `DATA_WID`, `REG_POS_WID`, `ROB_POS_WID`.
- Add `REG_NUM` (32) to that header.
- One natural sub-module, reg_file_rd_port. It takes the state arrays, the commit bypass inputs and one rs index, and produces val, busy and rob_pos. It is instantiated twice, for rs1 and rs2.

## Test plan
- Reset: drive rst low mid-run with busy registers → all queries return 0 / 0 / 0 immediately, before any clock edge.
- Rename then commit:
  - Issue rd=5, rob_pos=3; next cycle query rs1=5 → busy=1, rob_pos=3.
  - Commit rd=5, pos=3, val=0xDEADBEEF → same-cycle rs1_val=0xDEADBEEF, busy=0; next cycle busy=0 from state.
- Stale commit: rename x7→pos 2, then x7→pos 6, then commit x7, pos 2, val 0x11 → val[7]=0x11, busy stays 1, tag=6.
- Simultaneous issue and commit on x9 (issue pos 4, commit pos 1, val 0x22) → val=0x22, busy=1, tag=4.
- Rollback with JALR: rollback=1 together with reg_write x1=0x1000 and issue x2 → x1=0x1000; all busy=0; x2 not renamed.
- x0 and rdy:
  - Issue and commit to x0 → queries of x0 return 0 / not busy.
  - With rdy=0, a commit x3=0x55 leaves x3 unchanged.
